dcache_assoc: RTL

DCACHE_ASSOC -- requirements
Module: dcache_assoc

---
 rtl/cpu_types_pkg.sv | 22 ++
 rtl/lru_rank.sv | 18 +
 rtl/dcache_assoc.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_types_pkg.sv
// Shared types for the data cache: word type, address fields, FSM states and the
// address the hit counter is written to at the end of a flush.
package cpu_types_pkg;
  typedef logic [31:0] word_t;

  localparam int DC_SETS  = 8;
  localparam int DC_WORDS = 2;
  localparam int DC_IDX_W = $clog2(DC_SETS);
  localparam int DC_BLK_W = $clog2(DC_WORDS);
  localparam int DC_TAG_W = 32 - 2 - DC_IDX_W - DC_BLK_W;

  typedef struct packed {
    logic [DC_TAG_W-1:0] tag;
    logic [DC_IDX_W-1:0] idx;
    logic [DC_BLK_W-1:0] blkoff;
    logic [1:0]          bytoff;
  } dcachef_t;

  typedef enum logic [2:0] {IDLE, WB, FILL, FLUSH, CNT, DONE} dstate_t;

  localparam word_t HITCNT_ADDR = 32'h0000_3100;
endpackage

// File: rtl/lru_rank.sv
// Age-rank update for one set: hit way becomes rank 0 (MRU), younger ways age by one.
module lru_rank #(
  parameter int WAYS = 2,
  parameter int RW   = 1
) (
  input  logic [WAYS-1:0][RW-1:0] ranks_i,
  input  logic [RW-1:0]           hit_way_i,
  output logic [WAYS-1:0][RW-1:0] ranks_o
);
  logic [RW-1:0] hit_rank;
  assign hit_rank = ranks_i[hit_way_i];

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    assign ranks_o[w] = (hit_way_i == RW'(w))    ? '0 :
                        (ranks_i[w] < hit_rank)  ? ranks_i[w] + 1'b1 :
                                                   ranks_i[w];
  end
endmodule

// File: rtl/dcache_assoc.sv
// Set-associative write-back, write-allocate data cache with LRU replacement,
// flush-on-halt and a saturating hit counter dumped after the flush.
module dcache_assoc
  import cpu_types_pkg::*;
#(
  parameter int SETS  = DC_SETS,
  parameter int WAYS  = 2,
  parameter int WORDS = DC_WORDS
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        dmemREN_i,
  input  logic        dmemWEN_i,
  input  logic [31:0] dmemaddr_i,
  input  logic [31:0] dmemstore_i,
  input  logic        halt_i,
  output logic        dhit_o,
  output logic [31:0] dmemload_o,
  output logic        flushed_o,
  output logic        dREN_o,
  output logic        dWEN_o,
  output logic [31:0] daddr_o,
  output logic [31:0] dstore_o,
  input  logic        dwait_i,
  input  logic [31:0] dload_i
);
  localparam int IW   = $clog2(SETS);
  localparam int WOFF = $clog2(WORDS);
  localparam int OW   = (WORDS > 1) ? WOFF : 1;
  localparam int WW   = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int TW   = 32 - 2 - WOFF - IW;

  dstate_t state_q, state_d;
  logic [OW-1:0] word_q, word_d;
  logic [WW-1:0] vway_q, vway_d, fway_q, fway_d;
  logic [IW-1:0] fset_q, fset_d;
  logic [31:0]   hitcnt_q;
  logic [SETS-1:0][WAYS-1:0] valid_q, dirty_q;
  logic [TW-1:0] tag_q  [SETS][WAYS];
  word_t         data_q [SETS][WAYS][WORDS];

  logic [IW-1:0] req_idx;
  logic [TW-1:0] req_tag;
  logic [OW-1:0] req_word;
  logic [WW-1:0] hway, victim, lru_vic;
  logic hit, last_word, st_we, fill_we, fill_done, fl_clean, adv;

  assign req_word  = OW'(dmemaddr_i[31:2]) & OW'(WORDS - 1);
  assign req_idx   = IW'(dmemaddr_i >> (2 + WOFF));
  assign req_tag   = TW'(dmemaddr_i >> (2 + WOFF + IW));
  assign last_word = (word_q == OW'(WORDS - 1));
  assign flushed_o = (state_q == DONE);

  function automatic word_t mkaddr(input logic [TW-1:0] t, input logic [IW-1:0] i,
                                   input logic [OW-1:0] w);
    return (word_t'(t) << (2 + WOFF + IW)) | (word_t'(i) << (2 + WOFF)) | (word_t'(w) << 2);
  endfunction

  always_comb begin
    hit  = 1'b0;
    hway = '0;
    for (int w = 0; w < WAYS; w++)
      if (valid_q[req_idx][w] && tag_q[req_idx][w] == req_tag) begin
        hit  = 1'b1;
        hway = WW'(w);
      end
  end

  // Lowest-numbered invalid way wins; otherwise fall back to the LRU way.
  always_comb begin
    victim = lru_vic;
    for (int w = WAYS - 1; w >= 0; w--)
      if (!valid_q[req_idx][w]) victim = WW'(w);
  end

  if (WAYS > 1) begin : g_lru
    logic [SETS-1:0][WAYS-1:0][WW-1:0] lru_q;
    logic [WAYS-1:0][WW-1:0]           lru_new;

    lru_rank #(.WAYS(WAYS), .RW(WW)) u_lru (
      .ranks_i   (lru_q[req_idx]),
      .hit_way_i (hway),
      .ranks_o   (lru_new)
    );

    always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
        for (int s = 0; s < SETS; s++)
          for (int w = 0; w < WAYS; w++) lru_q[s][w] <= WW'(w);
      end else if (dhit_o) begin
        lru_q[req_idx] <= lru_new;
      end
    end

    always_comb begin
      lru_vic = '0;
      for (int w = 0; w < WAYS; w++)
        if (lru_q[req_idx][w] == WW'(WAYS - 1)) lru_vic = WW'(w);
    end
  end else begin : g_nolru
    assign lru_vic = '0;
  end

  always_comb begin
    state_d    = state_q;
    word_d     = word_q;
    vway_d     = vway_q;
    fset_d     = fset_q;
    fway_d     = fway_q;
    dhit_o     = 1'b0;
    dmemload_o = '0;
    dREN_o     = 1'b0;
    dWEN_o     = 1'b0;
    daddr_o    = '0;
    dstore_o   = '0;
    st_we      = 1'b0;
    fill_we    = 1'b0;
    fill_done  = 1'b0;
    fl_clean   = 1'b0;
    adv        = 1'b0;
    case (state_q)
      IDLE: begin
        if (halt_i) begin
          state_d = FLUSH;
          fset_d  = '0;
          fway_d  = '0;
          word_d  = '0;
        end else if (dmemREN_i || dmemWEN_i) begin
          if (hit) begin
            dhit_o = 1'b1;
            if (dmemREN_i) dmemload_o = data_q[req_idx][hway][req_word];
            else           st_we      = 1'b1;
          end else begin
            vway_d  = victim;
            word_d  = '0;
            state_d = (valid_q[req_idx][victim] && dirty_q[req_idx][victim]) ? WB : FILL;
          end
        end
      end
      WB: begin
        dWEN_o   = 1'b1;
        daddr_o  = mkaddr(tag_q[req_idx][vway_q], req_idx, word_q);
        dstore_o = data_q[req_idx][vway_q][word_q];
        if (!dwait_i) begin
          word_d = word_q + 1'b1;
          if (last_word) begin
            word_d  = '0;
            state_d = FILL;
          end
        end
      end
      FILL: begin
        dREN_o  = 1'b1;
        daddr_o = mkaddr(req_tag, req_idx, word_q);
        if (!dwait_i) begin
          fill_we = 1'b1;
          word_d  = word_q + 1'b1;
          if (last_word) begin
            fill_done = 1'b1;
            word_d    = '0;
            state_d   = IDLE;
          end
        end
      end
      FLUSH: begin
        if (valid_q[fset_q][fway_q] && dirty_q[fset_q][fway_q]) begin
          dWEN_o   = 1'b1;
          daddr_o  = mkaddr(tag_q[fset_q][fway_q], fset_q, word_q);
          dstore_o = data_q[fset_q][fway_q][word_q];
          if (!dwait_i) begin
            word_d = word_q + 1'b1;
            if (last_word) begin
              word_d   = '0;
              fl_clean = 1'b1;
              adv      = 1'b1;
            end
          end
        end else begin
          adv = 1'b1;
        end
      end
      CNT: begin
        dWEN_o   = 1'b1;
        daddr_o  = HITCNT_ADDR;
        dstore_o = hitcnt_q;
        if (!dwait_i) state_d = DONE;
      end
      DONE:    ;
      default: state_d = IDLE;
    endcase
    // Flush pointer walks way-minor within each set, then on to the counter dump.
    if (adv) begin
      if (fway_q == WW'(WAYS - 1)) begin
        fway_d = '0;
        if (fset_q == IW'(SETS - 1)) state_d = CNT;
        else                         fset_d  = fset_q + 1'b1;
      end else begin
        fway_d = fway_q + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= IDLE;
      word_q   <= '0;
      vway_q   <= '0;
      fset_q   <= '0;
      fway_q   <= '0;
      hitcnt_q <= '0;
      valid_q  <= '0;
      dirty_q  <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      vway_q  <= vway_d;
      fset_q  <= fset_d;
      fway_q  <= fway_d;
      if (dhit_o && hitcnt_q != '1) hitcnt_q <= hitcnt_q + 1'b1;
      if (st_we) dirty_q[req_idx][hway] <= 1'b1;
      if (fill_done) begin
        valid_q[req_idx][vway_q] <= 1'b1;
        dirty_q[req_idx][vway_q] <= 1'b0;
      end
      if (fl_clean) dirty_q[fset_q][fway_q] <= 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (st_we)     data_q[req_idx][hway][req_word] <= dmemstore_i;
    if (fill_we)   data_q[req_idx][vway_q][word_q] <= dload_i;
    if (fill_done) tag_q[req_idx][vway_q]          <= req_tag;
  end
endmodule
